// File: rtl/regfile_mp.sv
// Multi-port integer register file with an integrated per-register busy scoreboard.
// Writes and scoreboard updates land on clk_i; reads are combinational with optional same-cycle bypass.
module regfile_mp #(
  parameter int unsigned XLen      = 32,
  parameter int unsigned NReg      = 32,
  parameter int unsigned NRead     = 2,
  parameter int unsigned NWrite    = 1,
  parameter int unsigned ZeroReg   = 1,
  parameter int unsigned Bypass    = 1,
  localparam int unsigned NRegWidth = $clog2(NReg)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NRead-1:0][NRegWidth-1:0]     raddr_i,
  output logic [NRead-1:0][XLen-1:0]          rdata_o,
  output logic [NRead-1:0]                    rbusy_o,
  input  logic [NWrite-1:0]                   we_i,
  input  logic [NWrite-1:0][NRegWidth-1:0]    waddr_i,
  input  logic [NWrite-1:0][XLen-1:0]         wdata_i,
  input  logic                                iss_valid_i,
  input  logic [NRegWidth-1:0]                iss_rd_i,
  output logic [NReg-1:0]                     busy_vec_o
);

  logic [XLen-1:0] rf_q [NReg];
  logic [NReg-1:0] busy_q;
  logic [NReg-1:0] busy_d;

  function automatic logic is_zero_reg(input logic [NRegWidth-1:0] addr);
    return (ZeroReg != 0) && (addr == '0);
  endfunction

  // Clears from writeback first, then the issue set so a new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWrite; w++) begin
      if (we_i[w]) busy_d[waddr_i[w]] = 1'b0;
    end
    if (iss_valid_i) busy_d[iss_rd_i] = 1'b1;
    if (ZeroReg != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int r = 0; r < NReg; r++) rf_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int w = 0; w < NWrite; w++) begin
        if (we_i[w] && !is_zero_reg(waddr_i[w])) rf_q[waddr_i[w]] <= wdata_i[w];
      end
    end
  end

  // Read ports: later write ports override earlier ones in the bypass scan, matching storage priority.
  always_comb begin
    for (int k = 0; k < NRead; k++) begin
      rdata_o[k] = rf_q[raddr_i[k]];
      rbusy_o[k] = busy_q[raddr_i[k]];
      if ((Bypass != 0) && rst_ni) begin
        for (int w = 0; w < NWrite; w++) begin
          if (we_i[w] && (waddr_i[w] == raddr_i[k])) begin
            rdata_o[k] = wdata_i[w];
            rbusy_o[k] = (iss_valid_i && (iss_rd_i == raddr_i[k])) ? busy_q[raddr_i[k]] : 1'b0;
          end
        end
      end
      if (is_zero_reg(raddr_i[k])) begin
        rdata_o[k] = '0;
        rbusy_o[k] = 1'b0;
      end
    end
  end

  assign busy_vec_o = busy_q;

endmodule
